// File: rtl/sample_packetizer.sv
// Purpose: frames FIFO samples into packets {sync,seq} header, PAYLOAD_LEN words, XOR checksum.
// Latency: one cycle from FIFO head to out_data; PAYLOAD_LEN+2 valid cycles per packet when unstalled.
// Backpressure: out_ready low holds the output register and stops FIFO pops; an empty FIFO mid-packet drains.
module sample_packetizer #(
  parameter int          PAYLOAD_LEN = 64,
  parameter logic [15:0] SYNC_WORD   = 16'hA5A5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [15:0] pkt_count,
  output logic [15:0] underrun_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_CHECKSUM
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(PAYLOAD_LEN - 1);

  state_t      r_state;
  logic [31:0] r_data;
  logic        r_valid;
  logic        r_last;
  logic [31:0] r_acc;
  logic [15:0] r_word_cnt;
  logic [15:0] r_seq;
  logic [15:0] r_underrun;

  state_t      w_nxt_state;
  logic        w_load;
  logic        w_ld_word;
  logic [31:0] w_word;
  logic        w_word_last;
  logic        w_pop;
  logic        w_stall;
  logic        w_start;
  logic        w_cks;

  // The output register may take a new word when empty or when its word is being consumed.
  assign w_load = !r_valid || out_ready;

  // Next-state and per-cycle actions; the header never pops, so the first payload word stays at the FIFO head.
  always_comb begin
    w_nxt_state = r_state;
    w_ld_word   = 1'b0;
    w_word      = r_data;
    w_word_last = 1'b0;
    w_pop       = 1'b0;
    w_stall     = 1'b0;
    w_start     = 1'b0;
    w_cks       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_load && enable && !fifo_empty) begin
          w_start     = 1'b1;
          w_ld_word   = 1'b1;
          w_word      = {SYNC_WORD, r_seq};
          w_nxt_state = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (w_load) begin
          if (!fifo_empty) begin
            w_pop     = 1'b1;
            w_ld_word = 1'b1;
            w_word    = fifo_dout;
            if (r_word_cnt == LAST_IDX) begin
              w_nxt_state = S_CHECKSUM;
            end
          end else begin
            w_stall = 1'b1;
          end
        end
      end
      S_CHECKSUM: begin
        if (w_load) begin
          w_ld_word   = 1'b1;
          w_word      = r_acc;
          w_word_last = 1'b1;
          w_cks       = 1'b1;
          w_nxt_state = S_IDLE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Output register: load a new word, or drain once the held word has been accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= 32'h0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_ld_word) begin
      r_data  <= w_word;
      r_valid <= 1'b1;
      r_last  <= w_word_last;
    end else if (out_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  // Checksum accumulator and payload word counter, restarted with each header.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= 32'h0;
      r_word_cnt <= 16'h0;
    end else if (w_start) begin
      r_acc      <= 32'h0;
      r_word_cnt <= 16'h0;
    end else if (w_pop) begin
      r_acc      <= r_acc ^ fifo_dout;
      r_word_cnt <= r_word_cnt + 16'd1;
    end
  end

  // Sequence number advances (and wraps) as each checksum word is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq <= 16'h0;
    end else if (w_cks) begin
      r_seq <= r_seq + 16'd1;
    end
  end

  // Saturating count of cycles lost to an empty FIFO inside a packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun <= 16'h0;
    end else if (w_stall && (r_underrun != 16'hFFFF)) begin
      r_underrun <= r_underrun + 16'd1;
    end
  end

  assign fifo_rd_en   = w_pop;
  assign out_data     = r_data;
  assign out_valid    = r_valid;
  assign out_last     = r_last;
  assign pkt_count    = r_seq;
  assign underrun_cnt = r_underrun;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: doc/sample_packetizer.md
SAMPLE_PACKETIZER -- requirements
Module: sample_packetizer

Interface
REQ-001 Parameter PAYLOAD_LEN, default 64: payload samples per packet; legal range 2..65535.
REQ-002 Parameter SYNC_WORD, default 16'hA5A5: header sync pattern.
REQ-003 clk  input  1  single clock; the FIFO read-side clock.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 enable  input  1  permits starting new packets.
REQ-006 fifo_dout  input  32  FIFO head word (first-word-fall-through, valid when fifo_empty=0).
REQ-007 fifo_empty  input  1  FIFO empty flag.
REQ-008 fifo_rd_en  output  1  pops FIFO head; combinational.
REQ-009 out_data  output  32  packet stream data.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_last  output  1  marks the final word (checksum) of a packet.
REQ-012 out_ready  input  1  downstream accepts the word this cycle.
REQ-013 pkt_count  output  16  packets fully emitted; equals next sequence number.
REQ-014 underrun_cnt  output  16  stall cycles caused by an empty FIFO mid-packet; saturating.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 Packet format SHALL be: header {SYNC_WORD, seq[15:0]}, then PAYLOAD_LEN FIFO words in FIFO order, then checksum word = XOR of all payload words (out_last=1).
REQ-017 Output register: load = !out_valid || out_ready; out_data, out_valid, and out_last change only on load cycles or on drain (below).
REQ-018 Drain: if out_ready=1 and no new word is loaded, out_valid<=0 and out_last<=0 next cycle.
REQ-019 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-020 States: IDLE, PAYLOAD, CHECKSUM.
REQ-021 IDLE behaviour: if load && enable && !fifo_empty, load the header, clear out_last, clear the accumulator, set word_cnt=0, and go to PAYLOAD.
REQ-022 IDLE header trigger: the header load SHALL NOT pop the FIFO.
REQ-023 PAYLOAD load: if load && !fifo_empty, assert fifo_rd_en, load fifo_dout, XOR it into the accumulator, and increment word_cnt.
REQ-024 PAYLOAD exit: on the load with word_cnt==PAYLOAD_LEN-1, go to CHECKSUM.
REQ-025 PAYLOAD stall: if load && fifo_empty, do not pop, increment underrun_cnt (saturate at 16'hFFFF), and drain per REQ-018.
REQ-026 fifo_rd_en SHALL be 1 only in PAYLOAD with load && !fifo_empty; never in any other state.
REQ-027 CHECKSUM: if load, load the accumulator with out_last=1, increment seq/pkt_count (wrap 16'hFFFF -> 0), and go to IDLE.
REQ-028 Back-to-back packets: the next header MAY load in the cycle after the checksum load, giving zero bubble when out_ready=1.
REQ-029 Deasserting enable mid-packet SHALL NOT truncate the packet; it only blocks the next header.
REQ-030 Latency: FIFO word to out_data is 1 cycle; with out_ready=1 and the FIFO never empty, one packet takes PAYLOAD_LEN+2 consecutive valid cycles.
REQ-031 word_cnt is 16 bits; the accumulator is 32 bits.

Reset
REQ-032 On rst_n=0, outputs SHALL be: out_valid=0, out_last=0, out_data=0, fifo_rd_en=0, pkt_count=0, underrun_cnt=0, busy=0; state=IDLE, seq=0, word_cnt=0, accumulator=0.
REQ-033 Reset mid-packet SHALL discard the partial packet; after release, the first packet carries seq=0.

Verification (PAYLOAD_LEN=4)
REQ-034 FIFO holds 1,2,3,4; enable=1; out_ready=1 -> stream A5A50000,1,2,3,4,4 (last=1) on 6 consecutive cycles; pkt_count=1.
REQ-035 FIFO continuously supplied with 8 words, out_ready=1 -> second header A5A50001 directly follows the first checksum with no gap; second checksum = XOR of words 5..8.
REQ-036 out_ready=0 for 3 cycles while payload word 2 is valid -> word 2 held stable, fifo_rd_en=0 during the hold, and no word lost or duplicated.
REQ-037 FIFO empties after payload word 2 for 5 cycles -> out_valid drops, underrun_cnt=5, and the packet resumes correctly with 3,4 and checksum.
REQ-038 enable drops after the header -> the full 6-word packet still completes, no further header follows, and busy=0 afterwards.
REQ-039 rst_n pulsed low during payload word 3 -> all outputs zero immediately; the next packet header is A5A50000.
